imm_narrower: RTL

Converts 32-bit datapath values back into the 16-bit immediate field format, the inverse direction of the immediate extension path. Each value is checked for whether it can be represented as a 16-bit immediate under zero- or sign-extension. The block returns the narrowed field and a fits flag, with valid/ready handshakes on both sides and a 2-entry output buffer. It sits between the ALU/register write-back side and the instruction-assembly/debug path, and also serves as a round-trip checker for the extender.

---
 rtl/imm_narrower.sv | 89 ++++++++
 1 files changed

// File: rtl/imm_narrower.sv
// Narrows 32-bit values to 16-bit immediates with a fits flag, buffered in a 2-entry FIFO.
// Optional build macro IMM_SATURATE_EN: non-fitting values saturate instead of truncating.
module imm_narrower (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic        in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic        out_fits,
  output logic [7:0]  ovf_count
);

  // state | meaning
  // EMPTY | no buffered entries
  // ONE   | one entry buffered
  // TWO   | buffer full, input stalled
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]  state, state_nxt;
  logic        wr_ptr, rd_ptr;
  logic [16:0] mem [2];
  logic [16:0] last_q;
  logic        push, pop;
  logic        fits;
  logic [15:0] imm;

  always_comb begin
    if (in_op) fits = (&in_value[31:15]) | (~|in_value[31:15]);
    else       fits = ~|in_value[31:16];
    imm = in_value[15:0];
`ifdef IMM_SATURATE_EN
    if (!fits) begin
      if (in_op) imm = in_value[31] ? 16'h8000 : 16'h7FFF;
      else       imm = 16'hFFFF;
    end
`endif
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      last_q    <= '0;
      ovf_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        mem[wr_ptr] <= {imm, fits};
        wr_ptr      <= ~wr_ptr;
        if (!fits && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // When empty, keep showing the last delivered entry rather than stale FIFO contents.
  assign {out_imm, out_fits} = out_valid ? mem[rd_ptr] : last_q;

endmodule
